// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle of the MEM-stage load/store unit.
// The pipeline is the master; the load/store unit is the slave.
interface mem_access_unit_if;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic [1:0]  ReqSize;
   logic        ReqSigned;
   logic [31:0] ReqAddr;
   logic [31:0] ReqWData;
   logic        RespValid;
   logic [31:0] RespRData;
   logic        Misaligned;
   logic        Stall;

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
      input  ReqReady, RespValid, RespRData, Misaligned, Stall
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData,
      output ReqReady, RespValid, RespRData, Misaligned, Stall
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit driving a word-addressed, word-wide data memory.
// Sub-word stores are done as read-modify-write; sub-word loads are extended.
module mem_access_unit #(
   parameter int ADDR_W = 7
) (
   input  logic              Clk,
   input  logic              Rst_n,
   mem_access_unit_if.slave  req,
   output logic [ADDR_W-1:0] MemAddress,
   output logic [31:0]       MemWriteData,
   output logic              MemRead,
   output logic              MemWrite,
   input  logic [31:0]       MemReadData
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_READ,
      WRITE,
      RESP
   } state_t;

   state_t      state;
   logic [1:0]  lane;
   logic [1:0]  size;
   logic        is_signed;
   logic [15:0] store_data;

   logic        misaligned_req;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_value;
   logic [31:0] merged;
   logic        unused_addr_bits;

   // Address bits above the memory size wrap, so they are deliberately dropped.
   assign unused_addr_bits = ^req.ReqAddr[31:ADDR_W+2];

   assign misaligned_req = req.ReqSize[1] ? (req.ReqAddr[1:0] != 2'b00)
                                          : (req.ReqSize[0] & req.ReqAddr[0]);

   always_comb begin
      byte_sel   = MemReadData[{lane, 3'b000} +: 8];
      half_sel   = lane[1] ? MemReadData[31:16] : MemReadData[15:0];
      load_value = MemReadData;
      merged     = MemReadData;
      case (size)
         2'b00: begin
            load_value = {{24{is_signed & byte_sel[7]}}, byte_sel};
            merged[{lane, 3'b000} +: 8] = store_data[7:0];
         end
         2'b01: begin
            load_value = {{16{is_signed & half_sel[15]}}, half_sel};
            merged[{lane[1], 4'b0000} +: 16] = store_data;
         end
         default: begin
            load_value = MemReadData;
            merged     = MemReadData;
         end
      endcase
   end

   // Enables are pure state decodes so an async reset drops them immediately.
   assign req.ReqReady  = (state == IDLE);
   assign req.RespValid = (state == RESP);
   assign MemRead       = (state == LOAD) || (state == RMW_READ);
   assign MemWrite      = (state == WRITE);
   assign req.Stall     = ~req.RespValid & (req.ReqValid | (state != IDLE));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= IDLE;
         lane           <= 2'b00;
         size           <= 2'b00;
         is_signed      <= 1'b0;
         store_data     <= 16'h0000;
         MemAddress     <= '0;
         MemWriteData   <= 32'h0000_0000;
         req.RespRData  <= 32'h0000_0000;
         req.Misaligned <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req.ReqValid) begin
                  lane           <= req.ReqAddr[1:0];
                  size           <= req.ReqSize;
                  is_signed      <= req.ReqSigned;
                  store_data     <= req.ReqWData[15:0];
                  MemAddress     <= req.ReqAddr[ADDR_W+1:2];
                  req.Misaligned <= misaligned_req;
                  if (misaligned_req) begin
                     req.RespRData <= 32'h0000_0000;
                     state         <= RESP;
                  end else if (!req.ReqWrite) begin
                     state <= LOAD;
                  end else if (req.ReqSize[1]) begin
                     MemWriteData <= req.ReqWData;
                     state        <= WRITE;
                  end else begin
                     state <= RMW_READ;
                  end
               end
            end
            LOAD: begin
               req.RespRData <= load_value;
               state         <= RESP;
            end
            RMW_READ: begin
               MemWriteData <= merged;
               state        <= WRITE;
            end
            WRITE: begin
               req.RespRData <= 32'h0000_0000;
               state         <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a reference memory predicts every
// response, memory access and stall window, checked as the unit produces them.
module tb_mem_access_unit;

   logic        Clk;
   logic        Rst_n;
   logic [6:0]  MemAddress;
   logic [31:0] MemWriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] MemReadData;

   logic [31:0] mem    [128];
   logic [31:0] refMem [128];

   int checkCount = 0;
   int failCount  = 0;
   int cycle      = 0;
   int readCount  = 0;
   int writeCount = 0;
   int stallCount = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
      int          reads;
      int          writes;
      logic [6:0]  addr;
      logic [31:0] wdata;
      int          drive;
   } exp_t;

   exp_t sbQueue[$];

   mem_access_unit_if bus ();

   mem_access_unit #(.ADDR_W(7)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .req          (bus),
      .MemAddress   (MemAddress),
      .MemWriteData (MemWriteData),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .MemReadData  (MemReadData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cycle <= cycle + 1;

   assign MemReadData = mem[MemAddress];

   always @(posedge Clk) begin
      if (MemWrite) mem[MemAddress] <= MemWriteData;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Response monitor: everything observed between two responses belongs to the queue head.
   always @(negedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sbQueue.delete();
         readCount  = 0;
         writeCount = 0;
         stallCount = 0;
      end else begin
         if (bus.Stall) stallCount++;
         if (MemRead || MemWrite) begin
            checkOutput("rw_exclusive", 32'(MemRead & MemWrite), 32'd0);
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_mem_access", 32'(sbQueue.size()), 32'd1);
            end else begin
               checkOutput("mem_addr", 32'(MemAddress), 32'(sbQueue[0].addr));
               if (MemWrite) checkOutput("mem_wdata", MemWriteData, sbQueue[0].wdata);
            end
            if (MemRead) readCount++;
            if (MemWrite) writeCount++;
         end
         if (bus.RespValid) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_resp", 32'(sbQueue.size()), 32'd1);
            end else begin
               exp_t e;
               e = sbQueue.pop_front();
               checkOutput("resp_rdata", bus.RespRData, e.rdata);
               checkOutput("resp_misaligned", 32'(bus.Misaligned), 32'(e.mis));
               checkOutput("resp_latency", 32'(cycle - e.drive), 32'(e.lat));
               checkOutput("mem_read_cycles", 32'(readCount), 32'(e.reads));
               checkOutput("mem_write_cycles", 32'(writeCount), 32'(e.writes));
               checkOutput("stall_cycles", 32'(stallCount), 32'(e.lat));
            end
            readCount  = 0;
            writeCount = 0;
            stallCount = 0;
         end
      end
   end

   task automatic waitReady(output logic ok);
      int waited = 0;
      @(posedge Clk); #1;
      while (!bus.ReqReady && waited < 20) begin
         @(posedge Clk); #1;
         waited++;
      end
      ok = bus.ReqReady;
      if (!ok) checkOutput("ready_timeout", 32'(bus.ReqReady), 32'd1);
   endtask

   // Predicts the outcome from the reference memory, queues it, then drives one request.
   task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sg,
                                input logic [31:0] a, input logic [31:0] d);
      exp_t        e;
      logic        ok;
      logic [6:0]  idx;
      logic [31:0] old;
      logic [31:0] v;
      logic [31:0] mask;
      int          sh;
      waitReady(ok);
      if (!ok) return;
      idx      = a[8:2];
      old      = refMem[idx];
      e.addr   = idx;
      e.drive  = cycle;
      e.rdata  = 32'h0;
      e.wdata  = 32'h0;
      e.mis    = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
      e.reads  = 0;
      e.writes = 0;
      if (e.mis) begin
         e.lat = 1;
      end else if (!w) begin
         e.lat   = 2;
         e.reads = 1;
         if (sz == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            v  = (old >> sh) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
         end else if (sz == 2'b01) begin
            sh = a[1] ? 16 : 0;
            v  = (old >> sh) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
         end else begin
            v = old;
         end
         e.rdata = v;
      end else begin
         e.writes = 1;
         if (sz[1]) begin
            e.lat   = 2;
            e.wdata = d;
         end else begin
            e.lat   = 3;
            e.reads = 1;
            if (sz == 2'b00) begin
               sh   = 8 * int'(a[1:0]);
               mask = 32'h0000_00FF << sh;
            end else begin
               sh   = a[1] ? 16 : 0;
               mask = 32'h0000_FFFF << sh;
            end
            e.wdata = (old & ~mask) | ((d << sh) & mask);
         end
         refMem[idx] = e.wdata;
      end
      sbQueue.push_back(e);
      bus.ReqValid  = 1'b1;
      bus.ReqWrite  = w;
      bus.ReqSize   = sz;
      bus.ReqSigned = sg;
      bus.ReqAddr   = a;
      bus.ReqWData  = d;
      @(posedge Clk); #1;
      bus.ReqValid  = 1'b0;
   endtask

   initial begin
      logic ok;
      int   waited;
      Rst_n         = 1'b0;
      bus.ReqValid  = 1'b0;
      bus.ReqWrite  = 1'b0;
      bus.ReqSize   = 2'b00;
      bus.ReqSigned = 1'b0;
      bus.ReqAddr   = 32'h0;
      bus.ReqWData  = 32'h0;
      for (int i = 0; i < 128; i++) begin
         mem[i]    = 32'h1357_9BDF ^ (i * 32'h0101_0101);
         refMem[i] = 32'h1357_9BDF ^ (i * 32'h0101_0101);
      end
      mem[5]    = 32'h8899_AABB;
      refMem[5] = 32'h8899_AABB;

      #1;
      checkOutput("reset_ready", 32'(bus.ReqReady), 32'd1);
      checkOutput("reset_resp_valid", 32'(bus.RespValid), 32'd0);
      checkOutput("reset_misaligned", 32'(bus.Misaligned), 32'd0);
      checkOutput("reset_stall", 32'(bus.Stall), 32'd0);
      checkOutput("reset_mem_read", 32'(MemRead), 32'd0);
      checkOutput("reset_mem_write", 32'(MemWrite), 32'd0);
      checkOutput("reset_mem_addr", 32'(MemAddress), 32'd0);
      checkOutput("reset_mem_wdata", MemWriteData, 32'd0);
      checkOutput("reset_rdata", bus.RespRData, 32'd0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;

      $display("[TB] directed loads and stores on word 5");
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0016, 32'h0);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0015, 32'h0000_0011);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);

      $display("[TB] misaligned requests");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0013, 32'hCAFE_F00D);
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);

      $display("[TB] address wrap");
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);

      $display("[TB] random traffic");
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 9), $urandom);
      end

      $display("[TB] reset during RMW_READ");
      waitReady(ok);
      if (ok) begin
         bus.ReqValid  = 1'b1;
         bus.ReqWrite  = 1'b1;
         bus.ReqSize   = 2'b00;
         bus.ReqSigned = 1'b0;
         bus.ReqAddr   = 32'h0000_0024;
         bus.ReqWData  = 32'h0000_0077;
         @(posedge Clk); #1;
         bus.ReqValid  = 1'b0;
         checkOutput("rmw_read_before_reset", 32'(MemRead), 32'd1);
         #1 Rst_n = 1'b0;
         #1;
         checkOutput("rst_mem_read", 32'(MemRead), 32'd0);
         checkOutput("rst_mem_write", 32'(MemWrite), 32'd0);
         checkOutput("rst_ready", 32'(bus.ReqReady), 32'd1);
         checkOutput("rst_stall", 32'(bus.Stall), 32'd0);
         checkOutput("rst_resp_valid", 32'(bus.RespValid), 32'd0);
         @(posedge Clk); #1 Rst_n = 1'b1;
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0024, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0026, 32'h0000_5A5A);
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0026, 32'h0);

      waited = 0;
      while (sbQueue.size() != 0 && waited < 50) begin
         @(posedge Clk);
         waited++;
      end
      checkOutput("scoreboard_drain", 32'(sbQueue.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
